// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam logic signed [MD_WIDTH-1:0] DIV0_LO = '1;
  typedef enum logic [1:0] {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV} op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;
  function automatic logic is_div(input op_e o);
    return o == OP_DIVU || o == OP_DIV;
  endfunction
endpackage

// File: rtl/muldiv_e_div_step.sv
// div_step: one combinational restoring-division step on a {rem, quo} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;
  assign w_sh   = {i_rem, i_quo[WIDTH-1]};
  // rem < divisor always holds, so bit WIDTH of the difference is the borrow
  assign w_diff = w_sh - {1'b0, i_dvs};
  assign o_rem  = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo  = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};
endmodule

// File: rtl/muldiv_e.sv
// muldiv_e: iterative MULT/MULTU/DIV/DIVU unit with private HI/LO and MFHI/MFLO read port.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (IDLE -> FIX); divides stay iterative.
module muldiv_e
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] DataO,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  state_e             r_state;
  op_e                r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_sa;
  logic               r_sb;
  logic               r_div0;
  logic               r_done;

  logic               w_div;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [2*WIDTH-1:0] w_acc_init;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH-1:0]   w_rem_n;
  logic [WIDTH-1:0]   w_quo_n;
  logic [2*WIDTH-1:0] w_run_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_div      = is_div(op_e'(op));
  assign w_sa       = op[0] & srcA[WIDTH-1];
  assign w_sb       = op[0] & srcB[WIDTH-1];
  assign w_ma       = w_sa ? -srcA : srcA;
  assign w_mb       = w_sb ? -srcB : srcB;
  // Multiply keeps the multiplier in the low half; divide keeps the dividend there
  assign w_acc_init = {{WIDTH{1'b0}}, w_div ? w_ma : w_mb};

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_nxt  = {w_mul_sum, r_acc[WIDTH-1:1]};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem(r_acc[2*WIDTH-1:WIDTH]),
    .i_quo(r_acc[WIDTH-1:0]),
    .i_dvs(r_m),
    .o_rem(w_rem_n),
    .o_quo(w_quo_n)
  );

  assign w_run_nxt  = is_div(r_op) ? {w_rem_n, w_quo_n} : w_mul_nxt;

  // Sign flags are zero for unsigned ops, so no op check is needed here
  assign w_prod     = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo      = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem      = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi   = is_div(r_op) ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo   = is_div(r_op) ? (r_div0 ? WIDTH'(DIV0_LO) : w_quo) : w_prod[WIDTH-1:0];

  assign busy  = r_state != S_IDLE;
  assign done  = r_done;
  assign stall = busy & (start | rd_en | hi_we | lo_we);
  assign DataO = rd_sel ? r_hi : r_lo;

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_MULTU;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op_e'(op);
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_div0 <= srcB == '0;
            r_m    <= w_div ? w_mb : w_ma;
            r_cnt  <= CNT_W'(WIDTH - 1);
`ifdef MULDIV_FAST_MUL_EN
            r_acc   <= w_div ? w_acc_init : (2*WIDTH)'(w_ma) * (2*WIDTH)'(w_mb);
            r_state <= w_div ? S_RUN : S_FIX;
`else
            r_acc   <= w_acc_init;
            r_state <= S_RUN;
`endif
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_acc <= w_run_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_e.sv
// tb_muldiv_e: randomized self-checking bench for muldiv_e against an arithmetic reference model.
module tb_muldiv_e;
  logic        ref_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] DataO;
  logic        busy;
  logic        done;
  logic        stall;

  int n_chk = 0;
  int n_pass = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  always #5 ref_clk = ~ref_clk;

  muldiv_e dut (
    .ref_clk(ref_clk), .rst_n(rst_n), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .rd_en(rd_en), .rd_sel(rd_sel), .DataO(DataO), .busy(busy), .done(done), .stall(stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: p = 64'(sa * sb);
      2'd2: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;

  // Reference model: results appear a fixed number of edges after an accepted start
  always @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start) begin
        {p_hi, p_lo} = ref_res(op, srcA, srcB);
        m_left = op[1] ? DIV_LAT : MUL_LAT;
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  always @(negedge ref_clk) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("stall", 32'(stall), 32'((m_left > 0) && (start | rd_en | hi_we | lo_we)));
    chk("DataO", DataO, rd_sel ? m_hi : m_lo);
  end

  task automatic wait_done(input string nm, output int bc);
    int k = 0;
    bc = 0;
    while (k < 100) begin
      @(negedge ref_clk);
      if (done) break;
      bc += int'(busy);
      k++;
    end
    chk({nm, "_timeout"}, 32'(k < 100), 32'd1);
  endtask

  task automatic read_hl(input string nm, input logic [31:0] eh, input logic [31:0] el);
    @(posedge ref_clk); #1 rd_sel = 1'b1;
    @(negedge ref_clk) chk({nm, "_hi"}, DataO, eh);
    @(posedge ref_clk); #1 rd_sel = 1'b0;
    @(negedge ref_clk) chk({nm, "_lo"}, DataO, el);
  endtask

  // An MT write issued together with start must be discarded
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat, input string nm);
    int bc;
    @(posedge ref_clk); #1;
    start = 1'b1; op = o; srcA = a; srcB = b; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge ref_clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); srcA = $urandom; srcB = $urandom;
    wait_done(nm, bc);
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(lat));
    read_hl(nm, eh, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc, dn;
    repeat (3) @(posedge ref_clk);
    #1 rst_n = 1'b1;
    @(negedge ref_clk) chk("rst_lo", DataO, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge ref_clk); #1 rd_sel = 1'b1;
    @(negedge ref_clk) chk("rst_hi", DataO, 32'd0);
    @(posedge ref_clk); #1 rd_sel = 1'b0; lo_we = 1'b1; wdata = 32'h1234;
    @(posedge ref_clk); #1 lo_we = 1'b0;
    @(negedge ref_clk) chk("mtlo", DataO, 32'h1234);

    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, "multu_max");
    do_op(2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, "mult_neg");
    do_op(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, "div_neg");
    do_op(2'd2, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, DIV_LAT, "divu_zero");
    do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT, "div_ovf");

    // Start, MTHI and MFLO while busy: stalled, ignored, old LO visible
    @(posedge ref_clk); #1 start = 1'b1; op = 2'd2; srcA = 32'd100; srcB = 32'd7;
    @(posedge ref_clk); #1 start = 1'b0;
    repeat (3) @(posedge ref_clk);
    #1 start = 1'b1; op = 2'd0; srcA = 32'd5; srcB = 32'd5; rd_en = 1'b1; hi_we = 1'b1; wdata = 32'd1;
    @(negedge ref_clk) chk("busy_stall", 32'(stall), 32'd1);
    chk("busy_old_lo", DataO, 32'h8000_0000);
    @(posedge ref_clk); #1 start = 1'b0; rd_en = 1'b0; hi_we = 1'b0;
    wait_done("busy_divu", bc);
    read_hl("busy_divu", 32'd2, 32'd14);

    // Reset in the middle of a multiply
    @(posedge ref_clk); #1 start = 1'b1; op = 2'd0; srcA = 32'hFFFF_FFFF; srcB = 32'h0001_2345;
    @(posedge ref_clk); #1 start = 1'b0;
    repeat (9) @(posedge ref_clk);
    #1 rst_n = 1'b0;
    @(negedge ref_clk) chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_lo", DataO, 32'd0);
    @(posedge ref_clk); #1 rd_sel = 1'b1;
    @(negedge ref_clk) chk("midrst_hi", DataO, 32'd0);
    @(posedge ref_clk); #1 rst_n = 1'b1; rd_sel = 1'b0;
    dn = 0;
    repeat (40) @(negedge ref_clk) dn += int'(done);
    chk("midrst_no_done", 32'(dn), 32'd0);
    do_op(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT, "multu_6x7");

    // Fully random traffic; the compare process checks every cycle
    for (int i = 0; i < 2000; i++) begin
      @(posedge ref_clk); #1;
      start  = ($urandom_range(0, 7) == 0);
      op     = 2'($urandom);
      srcA   = pick();
      srcB   = pick();
      hi_we  = ($urandom_range(0, 15) == 0);
      lo_we  = ($urandom_range(0, 15) == 0);
      wdata  = $urandom;
      rd_en  = 1'($urandom);
      rd_sel = 1'($urandom);
    end
    @(posedge ref_clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rd_en = 1'b0;
    repeat (40) @(posedge ref_clk);
    @(negedge ref_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
